// File: rtl/alarm_control.sv
// Alarm time storage, set-mode editor and arm/stop/snooze control for the alarm trigger block.
// Define ALARM_SNOOZE_EN to compile in snooze support; without it snoozePulse is ignored and snoozeActive stays 0.
module alarm_control #(
    parameter int SNOOZE_MIN = 9
) (
    input  logic       clk5MHz,
    input  logic       reset,
    input  logic       setPulse,
    input  logic       incPulse,
    input  logic       armPulse,
    input  logic       stopPulse,
    input  logic       snoozePulse,
    input  logic [5:0] clockMinutes,
    input  logic [5:0] clockHours,
    output logic [5:0] alarmMinutes,
    output logic [5:0] alarmHours,
    output logic       alarmEnable,
    output logic       alarmClear,
    output logic [1:0] setMode,
    output logic       armed,
    output logic       snoozeActive
);

    typedef enum logic [1:0] {IDLE = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;

    state_t     state, stateNext;
    logic [5:0] storedHours, storedMinutes, storedHoursNext, storedMinutesNext;
    logic [5:0] shadowHours, shadowMinutes, shadowHoursNext, shadowMinutesNext;
    logic [5:0] snoozeHours, snoozeMinutes, snoozeHoursNext, snoozeMinutesNext;
    logic       stopped, stoppedNext, armedNext, snoozeActiveNext;
    logic       clearNext, enableNext;
    logic [5:0] alarmHoursNext, alarmMinutesNext;
    logic       snoozeReq;

`ifdef ALARM_SNOOZE_EN
    assign snoozeReq = snoozePulse;
`else
    logic unused_snooze;
    assign snoozeReq     = 1'b0;
    assign unused_snooze = snoozePulse;
`endif

    // Snooze target: current clock time plus SNOOZE_MIN, carrying into the hour.
    logic [6:0] snoozeSum;
    logic [5:0] snoozeMinCalc, snoozeHourCalc;
    always_comb begin
        snoozeSum      = {1'b0, clockMinutes} + 7'(SNOOZE_MIN);
        snoozeMinCalc  = snoozeSum[5:0];
        snoozeHourCalc = clockHours;
        if (snoozeSum >= 7'd60) begin
            snoozeMinCalc  = 6'(snoozeSum - 7'd60);
            snoozeHourCalc = (clockHours == 6'd23) ? 6'd0 : clockHours + 6'd1;
        end
    end

    // NOTE: every next-value signal takes its hold value first, so no path through this block infers a latch.
    always_comb begin
        stateNext         = state;
        storedHoursNext   = storedHours;
        storedMinutesNext = storedMinutes;
        shadowHoursNext   = shadowHours;
        shadowMinutesNext = shadowMinutes;
        snoozeHoursNext   = snoozeHours;
        snoozeMinutesNext = snoozeMinutes;
        snoozeActiveNext  = snoozeActive;
        armedNext         = armed;
        stoppedNext       = stopped;
        clearNext         = 1'b0;

        if (stopped && (clockMinutes != alarmMinutes))
            stoppedNext = 1'b0;

        if (setPulse) begin
            snoozeActiveNext = 1'b0;
            unique case (state)
                IDLE: begin
                    stateNext         = SET_HOUR;
                    shadowHoursNext   = storedHours;
                    shadowMinutesNext = storedMinutes;
                    clearNext         = 1'b1;
                end
                SET_HOUR: stateNext = SET_MIN;
                default: begin
                    stateNext         = IDLE;
                    storedHoursNext   = shadowHours;
                    storedMinutesNext = shadowMinutes;
                end
            endcase
        end else if (stopPulse) begin
            if (state == IDLE && armed) begin
                clearNext        = 1'b1;
                stoppedNext      = 1'b1;
                snoozeActiveNext = 1'b0;
            end
        end else if (snoozeReq) begin
            if (state == IDLE && armed) begin
                clearNext         = 1'b1;
                stoppedNext       = 1'b0;
                snoozeActiveNext  = 1'b1;
                snoozeHoursNext   = snoozeHourCalc;
                snoozeMinutesNext = snoozeMinCalc;
            end
        end else if (armPulse) begin
            if (state == IDLE) begin
                armedNext = ~armed;
                if (armed) begin
                    clearNext        = 1'b1;
                    snoozeActiveNext = 1'b0;
                end
            end
        end else if (incPulse) begin
            if (state == SET_HOUR)
                shadowHoursNext = (shadowHours == 6'd23) ? 6'd0 : shadowHours + 6'd1;
            else if (state == SET_MIN)
                shadowMinutesNext = (shadowMinutes == 6'd59) ? 6'd0 : shadowMinutes + 6'd1;
        end

        // Outputs are registered from the next state so they line up with setMode.
        enableNext = armedNext && (stateNext == IDLE) && !stoppedNext;
        if (stateNext != IDLE) begin
            alarmHoursNext   = shadowHoursNext;
            alarmMinutesNext = shadowMinutesNext;
        end else if (snoozeActiveNext) begin
            alarmHoursNext   = snoozeHoursNext;
            alarmMinutesNext = snoozeMinutesNext;
        end else begin
            alarmHoursNext   = storedHoursNext;
            alarmMinutesNext = storedMinutesNext;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            state         <= IDLE;
            storedHours   <= '0;
            storedMinutes <= '0;
            shadowHours   <= '0;
            shadowMinutes <= '0;
            snoozeHours   <= '0;
            snoozeMinutes <= '0;
            snoozeActive  <= 1'b0;
            armed         <= 1'b0;
            stopped       <= 1'b0;
            alarmClear    <= 1'b0;
            alarmEnable   <= 1'b0;
            alarmHours    <= '0;
            alarmMinutes  <= '0;
            setMode       <= 2'd0;
        end else begin
            state         <= stateNext;
            storedHours   <= storedHoursNext;
            storedMinutes <= storedMinutesNext;
            shadowHours   <= shadowHoursNext;
            shadowMinutes <= shadowMinutesNext;
            snoozeHours   <= snoozeHoursNext;
            snoozeMinutes <= snoozeMinutesNext;
            snoozeActive  <= snoozeActiveNext;
            armed         <= armedNext;
            stopped       <= stoppedNext;
            alarmClear    <= clearNext;
            alarmEnable   <= enableNext;
            alarmHours    <= alarmHoursNext;
            alarmMinutes  <= alarmMinutesNext;
            setMode       <= stateNext;
        end
    end

endmodule

// File: tb/tb_alarm_control.sv
// Self-checking bench for alarm_control: directed scenarios plus random pulses checked against a time-arithmetic model.
module tb_alarm_control;

    localparam int SNZ = 9;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk5MHz = 1'b0;
    logic       reset = 1'b0;
    logic       setPulse = 1'b0, incPulse = 1'b0, armPulse = 1'b0, stopPulse = 1'b0, snoozePulse = 1'b0;
    logic [5:0] clockMinutes = '0, clockHours = '0;
    logic [5:0] alarmMinutes, alarmHours;
    logic       alarmEnable, alarmClear, armed, snoozeActive;
    logic [1:0] setMode;

    alarm_control #(.SNOOZE_MIN(SNZ)) dut (
        .clk5MHz(clk5MHz), .reset(reset),
        .setPulse(setPulse), .incPulse(incPulse), .armPulse(armPulse),
        .stopPulse(stopPulse), .snoozePulse(snoozePulse),
        .clockMinutes(clockMinutes), .clockHours(clockHours),
        .alarmMinutes(alarmMinutes), .alarmHours(alarmHours),
        .alarmEnable(alarmEnable), .alarmClear(alarmClear),
        .setMode(setMode), .armed(armed), .snoozeActive(snoozeActive)
    );

    always #100 clk5MHz = ~clk5MHz;

    int total = 0;
    int bad = 0;
    int cm = 0, ch = 0;

    // Reference model: mode 0 idle, 1 editing hour, 2 editing minute; times kept as plain integers.
    int m_mode, m_sh, m_sm, m_st_h, m_st_m, m_sz_h, m_sz_m;
    bit m_armed, m_stopped, m_snz;
    int e_h, e_m, e_mode;
    bit e_en, e_clr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hours"},  32'(alarmHours),   32'(e_h));
        check({tag, ".mins"},   32'(alarmMinutes), 32'(e_m));
        check({tag, ".enable"}, 32'(alarmEnable),  32'(e_en));
        check({tag, ".clear"},  32'(alarmClear),   32'(e_clr));
        check({tag, ".mode"},   32'(setMode),      32'(e_mode));
        check({tag, ".armed"},  32'(armed),        32'(m_armed));
        check({tag, ".snooze"}, 32'(snoozeActive), 32'(m_snz));
    endtask

    task automatic model_reset();
        m_mode = 0; m_sh = 0; m_sm = 0; m_st_h = 0; m_st_m = 0; m_sz_h = 0; m_sz_m = 0;
        m_armed = 0; m_stopped = 0; m_snz = 0;
        e_h = 0; e_m = 0; e_mode = 0; e_en = 0; e_clr = 0;
    endtask

    task automatic model_step(input bit s, input bit i, input bit a, input bit p, input bit z);
        int t;
        if (m_stopped && cm != e_m) m_stopped = 0;
        e_clr = 0;
        if (s) begin
            m_snz = 0;
            if (m_mode == 0) begin
                m_mode = 1; m_sh = m_st_h; m_sm = m_st_m; e_clr = 1;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0; m_st_h = m_sh; m_st_m = m_sm;
            end
        end else if (p) begin
            if (m_mode == 0 && m_armed) begin
                e_clr = 1; m_stopped = 1; m_snz = 0;
            end
        end else if (z && SNZ_EN) begin
            if (m_mode == 0 && m_armed) begin
                t = (ch * 60 + cm + SNZ) % (24 * 60);
                e_clr = 1; m_stopped = 0; m_snz = 1;
                m_sz_h = t / 60; m_sz_m = t % 60;
            end
        end else if (a) begin
            if (m_mode == 0) begin
                if (m_armed) begin
                    e_clr = 1; m_snz = 0;
                end
                m_armed = !m_armed;
            end
        end else if (i) begin
            if (m_mode == 1) m_sh = (m_sh + 1) % 24;
            else if (m_mode == 2) m_sm = (m_sm + 1) % 60;
        end
        e_mode = m_mode;
        e_en = m_armed && m_mode == 0 && !m_stopped;
        if (m_mode != 0) begin
            e_h = m_sh; e_m = m_sm;
        end else if (m_snz) begin
            e_h = m_sz_h; e_m = m_sz_m;
        end else begin
            e_h = m_st_h; e_m = m_st_m;
        end
    endtask

    task automatic step(input string tag, input bit s, input bit i, input bit a, input bit p, input bit z);
        @(negedge clk5MHz);
        setPulse = s; incPulse = i; armPulse = a; stopPulse = p; snoozePulse = z;
        clockMinutes = 6'(cm); clockHours = 6'(ch);
        model_step(s, i, a, p, z);
        @(posedge clk5MHz);
        #1;
        check_all(tag);
        setPulse = 0; incPulse = 0; armPulse = 0; stopPulse = 0; snoozePulse = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk5MHz);
        reset = 1;
        setPulse = 0; incPulse = 0; armPulse = 0; stopPulse = 0; snoozePulse = 0;
        model_reset();
        @(posedge clk5MHz);
        #1;
        reset = 0;
        check_all(tag);
    endtask

    task automatic incs(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 0, 1, 0, 0, 0);
    endtask

    initial begin
        bit s, i, a, p, z;
        model_reset();

        // Reset state, then hour/minute wrap behaviour.
        do_reset("reset0");
        step("enter_hour", 1, 0, 0, 0, 0);
        check("enter_clear", 32'(alarmClear), 32'd1);
        incs("hour_up", 23);
        check("hour23", 32'(alarmHours), 32'd23);
        step("hour_wrap", 0, 1, 0, 0, 0);
        check("hour_wrap0", 32'(alarmHours), 32'd0);
        incs("hour_up2", 5);
        step("enter_min", 1, 0, 0, 0, 0);
        incs("min_up", 59);
        check("min59", 32'(alarmMinutes), 32'd59);
        step("min_wrap", 0, 1, 0, 0, 0);
        check("min_wrap0", 32'(alarmMinutes), 32'd0);
        check("min_wrap_hour", 32'(alarmHours), 32'd5);
        step("commit_5", 1, 0, 0, 0, 0);

        // Program 07:30 from reset.
        do_reset("reset1");
        step("s1", 1, 0, 0, 0, 0);
        incs("h7", 7);
        step("s2", 1, 0, 0, 0, 0);
        incs("m30", 30);
        step("s3", 1, 0, 0, 0, 0);
        check("commit_h", 32'(alarmHours), 32'd7);
        check("commit_m", 32'(alarmMinutes), 32'd30);
        check("commit_mode", 32'(setMode), 32'd0);
        step("idle_inc", 0, 1, 0, 0, 0);

        // Arm, stop inside the match minute, re-enable when the minute moves on.
        ch = 7; cm = 30;
        step("arm", 0, 0, 1, 0, 0);
        check("arm_en", 32'(alarmEnable), 32'd1);
        step("stop", 0, 0, 0, 1, 0);
        check("stop_clr", 32'(alarmClear), 32'd1);
        check("stop_en", 32'(alarmEnable), 32'd0);
        step("stop_hold", 0, 0, 0, 0, 0);
        check("stop_clr_1cyc", 32'(alarmClear), 32'd0);
        cm = 31;
        step("minute_moves", 0, 0, 0, 0, 0);
        check("reenable", 32'(alarmEnable), 32'd1);

        // setPulse beats stopPulse in the same cycle.
        cm = 30;
        step("set_stop", 1, 0, 0, 1, 0);
        check("set_stop_mode", 32'(setMode), 32'd1);
        check("set_stop_clr", 32'(alarmClear), 32'd1);
        step("set_stop_after", 0, 0, 0, 0, 0);
        step("to_min", 1, 0, 0, 0, 0);
        step("to_idle", 1, 0, 0, 0, 0);
        check("not_stopped", 32'(alarmEnable), 32'd1);

        // Snooze across midnight (ignored when the feature is compiled out).
        ch = 23; cm = 55;
        step("snooze", 0, 0, 0, 0, 1);
`ifdef ALARM_SNOOZE_EN
        check("snz_h", 32'(alarmHours), 32'd0);
        check("snz_m", 32'(alarmMinutes), 32'd4);
        check("snz_act", 32'(snoozeActive), 32'd1);
`else
        check("snz_off_act", 32'(snoozeActive), 32'd0);
        check("snz_off_m", 32'(alarmMinutes), 32'd30);
`endif
        step("snz_stop", 0, 0, 0, 1, 0);
        check("snz_stop_h", 32'(alarmHours), 32'd7);
        check("snz_stop_m", 32'(alarmMinutes), 32'd30);
        step("disarm", 0, 0, 1, 0, 0);
        check("disarm_clr", 32'(alarmClear), 32'd1);
        check("disarm_armed", 32'(armed), 32'd0);

        // Reset while editing 12:45 discards everything.
        step("e1", 1, 0, 0, 0, 0);
        incs("e_h", 5);
        step("e2", 1, 0, 0, 0, 0);
        incs("e_m", 15);
        check("edit_h", 32'(alarmHours), 32'd12);
        check("edit_m", 32'(alarmMinutes), 32'd45);
        do_reset("reset_mid_edit");
        step("post_reset_edit", 1, 0, 0, 0, 0);
        check("stored_zero_h", 32'(alarmHours), 32'd0);
        check("stored_zero_m", 32'(alarmMinutes), 32'd0);
        step("post_reset_min", 1, 0, 0, 0, 0);
        step("post_reset_idle", 1, 0, 0, 0, 0);

        // Random pulses, sometimes simultaneous, with the clock occasionally parked on the alarm time.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    ch = e_h; cm = e_m;
                end else begin
                    ch = int'($urandom_range(0, 23)); cm = int'($urandom_range(0, 59));
                end
            end
            s = ($urandom_range(0, 11) == 0);
            i = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 7) == 0);
            z = ($urandom_range(0, 7) == 0);
            step("rand", s, i, a, p, z);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
